// File: rtl/dc_pkg.sv
// dc_pkg: shared definitions for the two-way data-cache controller.
//   - controller state encoding
//   - tag-store entry field positions (V / D / LRU / tag)
//   - default address geometry and field slices (offset / index / tag)
package dc_pkg;

    // Default geometry: 21-bit physical address = tag[20:8] | index[7:4] | offset[3:0]
    localparam int DC_TAG_W  = 13;
    localparam int DC_IDX_W  = 4;
    localparam int DC_ADDR_W = 21;
    localparam int DC_OFF_W  = DC_ADDR_W - DC_TAG_W - DC_IDX_W;

    localparam int ADDR_OFF_LSB = 0;
    localparam int ADDR_IDX_LSB = DC_OFF_W;
    localparam int ADDR_TAG_LSB = DC_OFF_W + DC_IDX_W;

    // Tag-store entry: [15] V, [14] D, [13] LRU (way1 entry only), [12:0] tag
    localparam int ENT_W       = 16;
    localparam int ENT_V       = 15;
    localparam int ENT_D       = 14;
    localparam int ENT_LRU     = 13;
    localparam int ENT_TAG_LSB = 0;
    localparam int ENT_TAG_W   = 13;

    typedef logic [ENT_W-1:0] dc_entry_t;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_WB     = 3'd3,
        ST_FILL   = 3'd4,
        ST_UPDATE = 3'd5
    } dc_state_e;

endpackage

// File: rtl/dc_way_cmp.sv
// dc_way_cmp: valid / dirty decode and tag compare for one way's tag-store entry.
//   entry  in   raw tag-store entry for this way
//   tag    in   tag of the pending request
//   hit    out  entry valid and tag matches
//   valid  out  entry V bit
//   dirty  out  entry D bit
module dc_way_cmp
    import dc_pkg::*;
#(
    parameter int TAG_W = DC_TAG_W
) (
    input  logic [ENT_W-1:0] entry,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic             valid,
    output logic             dirty
);

    // The LRU bit is interpreted by the controller, not here.
    logic unused_lru;

    assign valid      = entry[ENT_V];
    assign dirty      = entry[ENT_D];
    assign hit        = valid && (entry[ENT_TAG_LSB +: TAG_W] == tag);
    assign unused_lru = entry[ENT_LRU];

endmodule

// File: rtl/dc_ctrl.sv
// dc_ctrl: two-way set-associative cache controller with an external tag store.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_wr/addr   load/store request; accepted on req_valid & req_ready
//   resp_valid/resp_way     one-cycle hit completion pulse and the way that hit
//   ts_index/ts_wr_n/ts_din tag-store index, active-low write enable, write data
//   ts_dout_way1/2          tag-store read data, combinational from ts_index
//   mem_req/mem_wr/addr     line transfer (writeback or fill), held until mem_ack
//   mem_ack                 one-cycle transfer completion
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_INIT   | clear both ways of every index, one index per cycle
// ST_IDLE   | ready for a request
// ST_LOOKUP | compare tags; hit completes, miss picks a victim
// ST_WB     | write back the dirty victim line
// ST_FILL   | fetch the requested line
// ST_UPDATE | install the new tag in the victim way, then re-lookup
module dc_ctrl
    import dc_pkg::*;
#(
    parameter int TAG_W  = DC_TAG_W,
    parameter int IDX_W  = DC_IDX_W,
    parameter int ADDR_W = DC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_way,
    output logic [IDX_W-1:0]  ts_index,
    output logic              ts_wr_n,
    output logic [ENT_W-1:0]  ts_din_way1,
    output logic [ENT_W-1:0]  ts_din_way2,
    input  logic [ENT_W-1:0]  ts_dout_way1,
    input  logic [ENT_W-1:0]  ts_dout_way2,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
);

    localparam int OFF_W   = ADDR_W - TAG_W - IDX_W;
    localparam int IDX_LSB = OFF_W;
    localparam int TAG_LSB = OFF_W + IDX_W;

    dc_state_e         state, state_nxt;
    logic [IDX_W-1:0]  init_cnt;
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic              lat_wr;
    logic              vic_way;
    logic [TAG_W-1:0]  vic_tag;

    logic              hit1, hit2, v1, v2, d1, d2;
    logic              vic_way_c, vic_dirty_c;
    logic              ts_we;
    dc_entry_t         new_ent;
    logic              unused_offset;

    assign unused_offset = ^req_addr[OFF_W-1:0];

    dc_way_cmp #(.TAG_W(TAG_W)) u_cmp_way1 (
        .entry (ts_dout_way1),
        .tag   (lat_tag),
        .hit   (hit1),
        .valid (v1),
        .dirty (d1)
    );

    dc_way_cmp #(.TAG_W(TAG_W)) u_cmp_way2 (
        .entry (ts_dout_way2),
        .tag   (lat_tag),
        .hit   (hit2),
        .valid (v2),
        .dirty (d2)
    );

    // Victim: first invalid way (way1 first), else the way the LRU bit names.
    // LRU = 1 means way1 was used last, so way2 is evicted.
    always_comb begin
        if (!v1) begin
            vic_way_c = 1'b0;
        end else if (!v2) begin
            vic_way_c = 1'b1;
        end else begin
            vic_way_c = ts_dout_way1[ENT_LRU];
        end
        vic_dirty_c = vic_way_c ? (v2 && d2) : (v1 && d1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '1;
            lat_tag  <= '0;
            lat_idx  <= '0;
            lat_wr   <= 1'b0;
            vic_way  <= 1'b0;
            vic_tag  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt - IDX_W'(1);
            end
            if (state == ST_IDLE && req_valid) begin
                lat_tag <= req_addr[TAG_LSB +: TAG_W];
                lat_idx <= req_addr[IDX_LSB +: IDX_W];
                lat_wr  <= req_wr;
            end
            if (state == ST_LOOKUP && !(hit1 || hit2)) begin
                vic_way <= vic_way_c;
                vic_tag <= vic_way_c ? ts_dout_way2[ENT_TAG_LSB +: TAG_W]
                                     : ts_dout_way1[ENT_TAG_LSB +: TAG_W];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_way    = 1'b0;
        ts_index    = lat_idx;
        ts_we       = 1'b0;
        // Untouched fields and ways are written back with what was read.
        ts_din_way1 = ts_dout_way1;
        ts_din_way2 = ts_dout_way2;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        new_ent     = '0;

        case (state)
            ST_INIT: begin
                // Down-counter 15..0 maps to index 0..15.
                ts_index    = ~init_cnt;
                ts_we       = 1'b1;
                ts_din_way1 = '0;
                ts_din_way2 = '0;
                if (init_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (hit1 || hit2) begin
                    resp_valid = 1'b1;
                    resp_way   = !hit1;
                    ts_we      = 1'b1;
                    state_nxt  = ST_IDLE;
                    if (hit1) begin
                        ts_din_way1[ENT_LRU] = 1'b1;
                        ts_din_way1[ENT_D]   = ts_dout_way1[ENT_D] | lat_wr;
                    end else begin
                        // LRU lives in the way1 entry, so a way2 hit still rewrites it.
                        ts_din_way1[ENT_LRU] = 1'b0;
                        ts_din_way2[ENT_D]   = ts_dout_way2[ENT_D] | lat_wr;
                    end
                end else if (vic_dirty_c) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_FILL;
                end
            end

            ST_WB: begin
                mem_req  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {vic_tag, lat_idx, {OFF_W{1'b0}}};
                if (mem_ack) begin
                    state_nxt = ST_FILL;
                end
            end

            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (mem_ack) begin
                    state_nxt = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                ts_we                      = 1'b1;
                new_ent[ENT_V]             = 1'b1;
                new_ent[ENT_TAG_LSB +: TAG_W] = lat_tag;
                if (!vic_way) begin
                    ts_din_way1          = new_ent;
                    ts_din_way1[ENT_LRU] = 1'b1;
                end else begin
                    ts_din_way2          = new_ent;
                    ts_din_way1[ENT_LRU] = 1'b0;
                end
                state_nxt = ST_LOOKUP;
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Gated by rst_n so the tag store is never written while reset is held.
    assign ts_wr_n = !(ts_we && rst_n);

endmodule

// File: tb/tb_dc_ctrl.sv
module tb_dc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [20:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_way;
    logic [3:0]  ts_index;
    logic        ts_wr_n;
    logic [15:0] ts_din_way1, ts_din_way2;
    logic [15:0] ts_dout_way1, ts_dout_way2;
    logic        mem_req;
    logic        mem_wr;
    logic [20:0] mem_addr;
    logic        mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    dc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_way     (resp_way),
        .ts_index     (ts_index),
        .ts_wr_n      (ts_wr_n),
        .ts_din_way1  (ts_din_way1),
        .ts_din_way2  (ts_din_way2),
        .ts_dout_way1 (ts_dout_way1),
        .ts_dout_way2 (ts_dout_way2),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag-store model: combinational read, write on rising edge when ts_wr_n low.
    logic [15:0] ts_mem1 [16];
    logic [15:0] ts_mem2 [16];
    assign ts_dout_way1 = ts_mem1[ts_index];
    assign ts_dout_way2 = ts_mem2[ts_index];
    always @(posedge clk) begin
        if (!ts_wr_n) begin
            ts_mem1[ts_index] <= ts_din_way1;
            ts_mem2[ts_index] <= ts_din_way2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] idx;
        logic       wr_n;
        logic       ready;
    } init_vec_t;

    typedef struct {
        logic [20:0] addr;
        logic        wr;
        logic [3:0]  idx;
        logic        exp_wb;
        logic [20:0] exp_wb_addr;
        logic        exp_fill;
        logic [20:0] exp_fill_addr;
        logic        exp_way;
        logic [15:0] exp_e1;
        logic [15:0] exp_e2;
    } txn_t;

    init_vec_t init_vecs [17];
    txn_t      txns [8];

    task automatic run_txn(input txn_t t, input int n);
        int          cyc;
        int          lat;
        int          writes;
        int          viol;
        int          wait_c;
        logic        got;
        logic        way_seen;
        logic        wb_seen;
        logic        fill_seen;
        logic [20:0] wb_a;
        logic [20:0] fill_a;
        string       tag;
        tag = $sformatf("txn%0d", n);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_wr    = t.wr;
        @(negedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; lat = 0; writes = 0; viol = 0; wait_c = 0;
        got = 1'b0; way_seen = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0;
        wb_a = '0; fill_a = '0;
        while (!got && cyc < 60) begin
            cyc++;
            if (!ts_wr_n) writes++;
            if (req_ready) viol++;
            if (resp_valid) begin
                got = 1'b1;
                way_seen = resp_way;
                lat = cyc;
                if (mem_req) viol++;
            end
            if (mem_req) begin
                if (mem_wr) begin
                    wb_seen = 1'b1;
                    wb_a = mem_addr;
                end else begin
                    fill_seen = 1'b1;
                    fill_a = mem_addr;
                end
                mem_ack = (wait_c == 1);
                wait_c = mem_ack ? 0 : wait_c + 1;
            end else begin
                mem_ack = 1'b0;
                wait_c = 0;
            end
            @(negedge clk); #1;
        end
        mem_ack = 1'b0;
        check({tag, "_resp"}, {31'd0, got}, 32'd1);
        check({tag, "_way"}, {31'd0, way_seen}, {31'd0, t.exp_way});
        check({tag, "_wb_seen"}, {31'd0, wb_seen}, {31'd0, t.exp_wb});
        if (t.exp_wb) check({tag, "_wb_addr"}, {11'd0, wb_a}, {11'd0, t.exp_wb_addr});
        check({tag, "_fill_seen"}, {31'd0, fill_seen}, {31'd0, t.exp_fill});
        if (t.exp_fill) check({tag, "_fill_addr"}, {11'd0, fill_a}, {11'd0, t.exp_fill_addr});
        else check({tag, "_hit_latency"}, lat, 32'd1);
        check({tag, "_ts_writes"}, writes, t.exp_fill ? 32'd2 : 32'd1);
        check({tag, "_protocol"}, viol, 32'd0);
        check({tag, "_entry_way1"}, {16'd0, ts_mem1[t.idx]}, {16'd0, t.exp_e1});
        check({tag, "_entry_way2"}, {16'd0, ts_mem2[t.idx]}, {16'd0, t.exp_e2});
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) begin
            ts_mem1[i] = 16'hDEAD;
            ts_mem2[i] = 16'hBEEF;
        end
        for (int i = 0; i < 16; i++) init_vecs[i] = '{i[3:0], 1'b0, 1'b0};
        init_vecs[16] = '{4'd0, 1'b1, 1'b1};

        //             addr        wr  idx  wb   wb_addr     fill  fill_addr   way   e1        e2
        txns[0] = '{21'h00120, 1'b0, 4'd2, 1'b0, 21'h0,     1'b1, 21'h00120, 1'b0, 16'hA001, 16'h0000};
        txns[1] = '{21'h00124, 1'b1, 4'd2, 1'b0, 21'h0,     1'b0, 21'h0,     1'b0, 16'hE001, 16'h0000};
        txns[2] = '{21'h00220, 1'b0, 4'd2, 1'b0, 21'h0,     1'b1, 21'h00220, 1'b1, 16'hC001, 16'h8002};
        txns[3] = '{21'h00320, 1'b0, 4'd2, 1'b1, 21'h00120, 1'b1, 21'h00320, 1'b0, 16'hA003, 16'h8002};
        txns[4] = '{21'h00228, 1'b1, 4'd2, 1'b0, 21'h0,     1'b0, 21'h0,     1'b1, 16'h8003, 16'hC002};
        txns[5] = '{21'h00420, 1'b0, 4'd2, 1'b0, 21'h0,     1'b1, 21'h00420, 1'b0, 16'hA004, 16'hC002};
        txns[6] = '{21'h00520, 1'b0, 4'd2, 1'b1, 21'h00220, 1'b1, 21'h00520, 1'b1, 16'h8004, 16'h8005};
        txns[7] = '{21'h1FFF5F, 1'b0, 4'd5, 1'b0, 21'h0,    1'b1, 21'h1FFF50, 1'b0, 16'hBFFF, 16'h0000};

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_ts_wr_n", {31'd0, ts_wr_n}, 32'd1);
        check("rst_resp_way", {31'd0, resp_way}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            #1;
            check($sformatf("init%0d_ready", k), {31'd0, req_ready}, {31'd0, init_vecs[k].ready});
            check($sformatf("init%0d_wr_n", k), {31'd0, ts_wr_n}, {31'd0, init_vecs[k].wr_n});
            if (!init_vecs[k].wr_n) begin
                check($sformatf("init%0d_index", k), {28'd0, ts_index}, {28'd0, init_vecs[k].idx});
                check($sformatf("init%0d_din", k), {ts_din_way1, ts_din_way2}, 32'd0);
            end
            @(negedge clk);
        end
        #1;
        for (int i = 0; i < 16; i++)
            check($sformatf("init_clear%0d", i), {ts_mem1[i], ts_mem2[i]}, 32'd0);

        // mem_ack in IDLE is ignored
        mem_ack = 1'b1;
        @(negedge clk); #1;
        mem_ack = 1'b0;
        check("idle_ack_ready", {31'd0, req_ready}, 32'd1);
        check("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);

        for (int n = 0; n < 8; n++) run_txn(txns[n], n);

        // Reset during FILL: idx2 way1 is clean and LRU names way1, so no writeback.
        req_valid = 1'b1; req_addr = 21'h00620; req_wr = 1'b0;
        @(negedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rstfill_mem_req", {31'd0, mem_req}, 32'd1);
        check("rstfill_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rstfill_addr", {11'd0, mem_addr}, 32'h00620);
        rst_n = 1'b0;
        #1;
        check("rstfill_drop_req", {31'd0, mem_req}, 32'd0);
        check("rstfill_ts_wr_n", {31'd0, ts_wr_n}, 32'd1);
        check("rstfill_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reinit_index0", {28'd0, ts_index}, 32'd0);
        check("reinit_wr_n", {31'd0, ts_wr_n}, 32'd0);
        repeat (16) @(negedge clk);
        #1;
        check("reinit_ready", {31'd0, req_ready}, 32'd1);
        check("reinit_clear_idx2", {ts_mem1[2], ts_mem2[2]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
